// File: rtl/mem_responder.sv
// Word RAM responder for the CPU memory port. It has a fixed read latency, address
// checking and a saturating error counter. Every edge out of reset samples one request.
module mem_responder #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        wr,
  input  logic [31:0] WriteDataMem,
  output logic [31:0] MemData,
  output logic        MemValid,
  output logic        AddrErr,
  output logic [7:0]  ErrCount
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LAST  = READ_LATENCY - 1;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("mem_responder: READ_LATENCY must be in 1..4");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
    $error("mem_responder: ADDR_WIDTH must be in 1..29");
  end

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } slot_t;

  logic [31:0]           mem_q [DEPTH];
  slot_t                 slot_q [READ_LATENCY];
  slot_t                 slot_d [READ_LATENCY];
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] idx_c;
  logic                  misaligned_c, oor_c, err_c, wr_en_c;
  logic [31:0]           resp_data_c;

  // Request decode: misaligned accesses are aligned down, out-of-range ones are dropped.
  always_comb begin
    idx_c        = Address[ADDR_WIDTH+1:2];
    misaligned_c = |Address[1:0];
    oor_c        = |(Address >> (ADDR_WIDTH + 2));
    err_c        = misaligned_c | oor_c;
    wr_en_c      = wr & ~oor_c;
    if (wr) begin
      resp_data_c = wr_en_c ? WriteDataMem : 32'd0;
    end else begin
      resp_data_c = oor_c ? 32'd0 : mem_q[idx_c];
    end
  end

  // RAM has no reset, so its contents survive reset. Writes are blocked while reset is held.
  always_ff @(posedge clock) begin
    if (reset && wr_en_c) begin
      mem_q[idx_c] <= WriteDataMem;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < READ_LATENCY; i++) begin
      slot_d[i] = '0;
    end
    slot_d[0].valid = 1'b1;
    slot_d[0].err   = err_c;
    slot_d[0].data  = resp_data_c;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      slot_d[i] = slot_q[i-1];
    end
    err_cnt_d = (err_c && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        slot_q[i] <= '0;
      end
      err_cnt_q <= 8'd0;
    end else begin
      slot_q    <= slot_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign MemData  = slot_q[LAST].data;
  assign MemValid = slot_q[LAST].valid;
  assign AddrErr  = slot_q[LAST].err;
  assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder. A word-array reference model predicts each response.
// A separate monitor checks the data, the error flag and the arrival cycle.
module tb_mem_responder;

  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0;
  logic        wr = 1'b0;
  logic [31:0] WriteDataMem = '0;
  logic [31:0] MemData;
  logic        MemValid;
  logic        AddrErr;
  logic [7:0]  ErrCount;

  mem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .Address(Address), .wr(wr),
    .WriteDataMem(WriteDataMem), .MemData(MemData), .MemValid(MemValid),
    .AddrErr(AddrErr), .ErrCount(ErrCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [1 << AW];
  int          model_cnt = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at negedge+2. Drives one request and lets the next rising edge sample it,
  // then returns at the following negedge+2.
  task automatic issue(input logic [31:0] addr, input logic w, input logic [31:0] wd,
                       input string tag);
    exp_t e;
    logic [AW-1:0] idx;
    logic oor, mis;
    Address = addr; wr = w; WriteDataMem = wd;
    @(posedge clock);
    idx = addr[AW+1:2];
    oor = (addr >> (AW + 2)) != 0;
    mis = addr[1:0] != 2'b00;
    if (w) begin
      e.data = oor ? 32'd0 : wd;
      if (!oor) model_mem[idx] = wd;
    end else begin
      e.data = oor ? 32'd0 : model_mem[idx];
    end
    e.err = oor | mis;
    if (e.err && model_cnt < 255) model_cnt++;
    e.cyc = cyc + LAT;
    e.tag = tag;
    sb.push_back(e);
    @(negedge clock); #2;
  endtask

  // Holds reset for one rising edge. A write is driven meanwhile and must be ignored.
  task automatic pulse_reset();
    reset = 1'b0;
    Address = 32'h0000_0100; wr = 1'b1; WriteDataMem = 32'hBAD0_BAD0;
    #1;
    check("rst_valid", 32'(MemValid), 32'd0);
    check("rst_data", MemData, 32'd0);
    check("rst_err", 32'(AddrErr), 32'd0);
    check("rst_cnt", 32'(ErrCount), 32'd0);
    sb.delete();
    model_cnt = 0;
    @(posedge clock);
    @(negedge clock); #2;
    reset = 1'b1;
  endtask

  // Monitor: pops one expectation per valid response and checks when it arrived.
  always @(negedge clock) begin
    if (!reset) begin
      check("valid_in_reset", 32'(MemValid), 32'd0);
    end else begin
      check("err_count", 32'(ErrCount), 32'(model_cnt));
      if (MemValid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got MemValid=1 data 0x%08h, expected no response", MemData);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_data"}, MemData, e.data);
          check({e.tag, "_err"}, 32'(AddrErr), 32'(e.err));
          check({e.tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL missing_resp %s: got MemValid=0 at cycle %0d, expected a response by cycle %0d",
                 sb[0].tag, cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] a;
    int unsigned r;
    repeat (3) @(negedge clock);
    #2;
    check("por_valid", 32'(MemValid), 32'd0);
    check("por_data", MemData, 32'd0);
    check("por_cnt", 32'(ErrCount), 32'd0);
    reset = 1'b1;

    // Fill the whole RAM so every later read has a known model value.
    for (int i = 0; i < (1 << AW); i++) issue(32'(i) << 2, 1'b1, $urandom, "fill");

    issue(32'h10, 1'b1, 32'hDEAD_BEEF, "wr_10");
    issue(32'h10, 1'b0, 32'h0, "rd_10");

    issue(32'h0, 1'b1, 32'h11, "pre0");
    issue(32'h4, 1'b1, 32'h22, "pre1");
    issue(32'h8, 1'b1, 32'h33, "pre2");
    issue(32'hC, 1'b1, 32'h44, "pre3");
    for (int i = 0; i < 4; i++) issue(32'(i) << 2, 1'b0, 32'h0, "pipe_rd");

    issue(32'h22, 1'b1, 32'h1234_5678, "mis_wr");
    issue(32'h20, 1'b0, 32'h0, "mis_rd");

    issue(32'h400, 1'b1, 32'hAAAA_AAAA, "oor_wr");
    issue(32'h000, 1'b0, 32'h0, "oor_rd0");
    issue(32'h400, 1'b0, 32'h0, "oor_rd");

    issue(32'h104, 1'b1, 32'hCAFE_F00D, "pre_rst_wr");
    issue(32'h104, 1'b0, 32'h0, "inflight0");
    issue(32'h10, 1'b0, 32'h0, "inflight1");
    pulse_reset();
    issue(32'h104, 1'b0, 32'h0, "post_rst_rd");
    issue(32'h100, 1'b0, 32'h0, "ignored_wr_rd");
    issue(32'h20, 1'b0, 32'h0, "post_rst_rd20");

    for (int i = 0; i < 300; i++) issue(32'h21, 1'b0, 32'h0, "sat_rd");
    check("sat_255", 32'(ErrCount), 32'd255);

    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, (1 << AW) - 1)) << 2;
      else if (r < 8) a = (32'($urandom_range(0, (1 << AW) - 1)) << 2) | 32'($urandom_range(1, 3));
      else            a = $urandom | 32'h0000_0400;
      issue(a, 1'($urandom_range(0, 1)), $urandom, "rand");
    end
    for (int i = 0; i < int'(LAT); i++) issue(32'h0, 1'b0, 32'h0, "drain");

    reset = 1'b0;
    sb.delete();
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's single-port memory interface: the CPU drives `Address`, `wr` and `WriteDataMem`; this block returns `MemData`.
- It replaces the fixed-timing `Memoria` model with a word RAM that has a configurable read latency, write handling, address checking and error reporting.
- It sits between the CPU's address mux and its IR/MDR loads.
- It gives the CPU's control unit a response-valid strobe and error flags, so it can sequence memory stalls and address exceptions.

Parameters:
- ADDR_WIDTH, 8, number of word-index bits; capacity is 2^ADDR_WIDTH 32-bit words.
- READ_LATENCY, 1, cycles from request sample to `MemData` valid; legal range 1..4.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Address  input  32  byte address from the CPU.
- wr  input  1  1 = write request, 0 = read request; a request is sampled on every rising edge.
- WriteDataMem  input  32  write data; used when wr=1.
- MemData  output  32  response data.
- MemValid  output  1  MemData/AddrErr describe the request sampled READ_LATENCY edges earlier.
- AddrErr  output  1  the request now reported was misaligned or out of range.
- ErrCount  output  8  saturating count of erroneous requests since reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - MemData=0, MemValid=0, AddrErr=0, ErrCount=0.
  - All pipeline valid bits cleared.
  - RAM contents are NOT cleared.
  - While reset=0, requests are ignored: no writes, no pipeline entries.
- Request sampling: each rising edge with reset=1 captures one request.
  - Word index = Address[ADDR_WIDTH+1:2].
  - misaligned = (Address[1:0] != 0).
  - out_of_range = (Address[31:ADDR_WIDTH+2] != 0).
- Write request (wr=1):
  - Legal (not out_of_range): the RAM word at the word index is written with WriteDataMem at that edge.
  - Misaligned is still legal for writing; the access is aligned down and AddrErr is flagged.
  - out_of_range: the write is suppressed; RAM is unchanged.
  - Response slot data = WriteDataMem (write-first echo) if the write happened, else 0.
- Read request (wr=0):
  - Response slot data = RAM word at the aligned-down index, as stored after all writes committed on earlier edges.
  - out_of_range: response data = 0.
- Pipeline:
  - Shift register of READ_LATENCY stages holding {valid, err, data}.
  - The stage-0 data value is captured at the sampling edge.
  - The request sampled at edge N appears on MemData/MemValid/AddrErr after edge N+READ_LATENCY-1, i.e. visible during the cycle following that edge. With READ_LATENCY=1 it is visible in the cycle after the sampling edge.
  - Outputs are registered; there is no combinational path from inputs to outputs.
  - A new request is accepted every cycle; there is no back-pressure.
- Read after write: a read sampled at edge N+1 to the word written at edge N returns the new data, with no hazard at any latency.
- Back-to-back writes to the same word: the last one wins.
- Error accounting:
  - AddrErr = misaligned OR out_of_range, carried through the pipeline with the data.
  - ErrCount increments by 1 when an erroneous request is sampled (not when it is reported).
  - ErrCount saturates at 255.
- MemValid is 0 during the first READ_LATENCY cycles after reset release, then 1 every cycle.
- Reset asserted mid-operation: in-flight responses are discarded (MemValid=0 immediately); RAM keeps every write already committed.
- READ_LATENCY outside 1..4: elaboration error.

Test Plan:
1. Basic write/read, READ_LATENCY=1:
   - Stimulus: write 0xDEADBEEF to 0x10, then read 0x10 on the next cycle.
   - Required: the write slot echoes 0xDEADBEEF with MemValid=1, AddrErr=0; the following slot reads 0xDEADBEEF.
2. Latency pipeline, READ_LATENCY=3:
   - Stimulus: preload words 0..3 with 0x11, 0x22, 0x33, 0x44; issue four reads 0x0, 0x4, 0x8, 0xC on consecutive edges.
   - Required: MemData = 0x11, 0x22, 0x33, 0x44 appear on four consecutive cycles, starting 3 edges after the first request; MemValid stays 1.
3. Misaligned:
   - Stimulus: write 0x12345678 to 0x22.
   - Required: word 8 (0x20) holds 0x12345678; AddrErr=1 in that slot; ErrCount=1. A subsequent read of 0x20 returns 0x12345678 with AddrErr=0.
4. Out of range, ADDR_WIDTH=8:
   - Stimulus: write 0xAAAAAAAA to 0x400.
   - Required: slot data 0, AddrErr=1; a read of 0x000 still returns its previous value; ErrCount incremented.
5. Reset mid-flight, READ_LATENCY=4:
   - Stimulus: issue two reads, then pulse reset low for 1 cycle.
   - Required: MemValid=0 and MemData=0 immediately; no stale response appears afterwards; previously written data is still readable.
6. Counter saturation:
   - Stimulus: 300 consecutive misaligned reads.
   - Required: ErrCount reaches 255 and holds at 255.
